// File: rtl/fp_result_rob_if.sv
// Issue, writeback and retire signals of the FP in-order result buffer.
// Master is the FP pipeline side; slave is the buffer itself.
interface fp_result_rob_if #(
  parameter int DEPTH  = 4,
  parameter int NUM_WB = 2,
  parameter int RES_W  = 64,
  parameter int FLAG_W = 5
);
  localparam int TAG_W = $clog2(DEPTH);

  logic                     alloc_valid_i;
  logic                     alloc_ready_o;
  logic [TAG_W-1:0]         alloc_tag_o;
  logic [4:0]               alloc_rd_i;
  logic [NUM_WB-1:0]        wb_valid_i;
  logic [NUM_WB*TAG_W-1:0]  wb_tag_i;
  logic [NUM_WB*RES_W-1:0]  wb_result_i;
  logic [NUM_WB*FLAG_W-1:0] wb_flags_i;
  logic                     ret_valid_o;
  logic                     ret_ready_i;
  logic [4:0]               ret_rd_o;
  logic [RES_W-1:0]         ret_result_o;
  logic [FLAG_W-1:0]        ret_flags_o;
  logic                     flush_i;
  logic [FLAG_W-1:0]        fflags_o;
  logic                     fflags_clr_i;
  logic                     empty_o;

  modport master (
    output alloc_valid_i, alloc_rd_i, wb_valid_i, wb_tag_i, wb_result_i, wb_flags_i,
           ret_ready_i, flush_i, fflags_clr_i,
    input  alloc_ready_o, alloc_tag_o, ret_valid_o, ret_rd_o, ret_result_o, ret_flags_o,
           fflags_o, empty_o
  );

  modport slave (
    input  alloc_valid_i, alloc_rd_i, wb_valid_i, wb_tag_i, wb_result_i, wb_flags_i,
           ret_ready_i, flush_i, fflags_clr_i,
    output alloc_ready_o, alloc_tag_o, ret_valid_o, ret_rd_o, ret_result_o, ret_flags_o,
           fflags_o, empty_o
  );
endinterface

// File: rtl/fp_result_rob.sv
// In-order completion buffer: tags FP ops, takes out-of-order writebacks, retires in issue order.
// Writeback-to-retire 1 cycle; alloc stalls on registered full only, retire waits on ret_ready_i.
module fp_result_rob #(
  parameter int DEPTH  = 4,
  parameter int NUM_WB = 2,
  parameter int RES_W  = 64,
  parameter int FLAG_W = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  fp_result_rob_if.slave rob
);
  localparam int TAG_W = $clog2(DEPTH);
  typedef logic [TAG_W:0] ptr_t;
  localparam ptr_t PTR_ONE = ptr_t'(1);

  ptr_t              head, tail;
  logic [DEPTH-1:0]  busy, done;
  logic [4:0]        rd_q  [DEPTH];
  logic [RES_W-1:0]  res_q [DEPTH];
  logic [FLAG_W-1:0] flg_q [DEPTH];
  logic [FLAG_W-1:0] fflags_q;

  logic [TAG_W-1:0]  head_idx, tail_idx;
  logic              full, alloc_fire, ret_fire;
  logic [DEPTH-1:0]  wb_hit;
  logic [RES_W-1:0]  wb_res [DEPTH];
  logic [FLAG_W-1:0] wb_flg [DEPTH];

  assign head_idx   = head[TAG_W-1:0];
  assign tail_idx   = tail[TAG_W-1:0];
  assign full       = (head_idx == tail_idx) && (head[TAG_W] != tail[TAG_W]);
  assign alloc_fire = rob.alloc_valid_i && !full;
  assign ret_fire   = rob.ret_valid_o && rob.ret_ready_i;

  assign rob.alloc_ready_o = !full;
  assign rob.alloc_tag_o   = tail_idx;
  assign rob.empty_o       = (head == tail);
  assign rob.ret_valid_o   = busy[head_idx] && done[head_idx];
  assign rob.ret_rd_o      = rd_q[head_idx];
  assign rob.ret_result_o  = res_q[head_idx];
  assign rob.ret_flags_o   = flg_q[head_idx];
  assign rob.fflags_o      = fflags_q;

  // Ports scanned high to low so the lowest-indexed port claiming an entry wins.
  always_comb begin
    wb_hit = '0;
    for (int e = 0; e < DEPTH; e++) begin
      wb_res[e] = '0;
      wb_flg[e] = '0;
    end
    for (int e = 0; e < DEPTH; e++) begin
      for (int k = NUM_WB - 1; k >= 0; k--) begin
        if (rob.wb_valid_i[k] && (rob.wb_tag_i[k*TAG_W +: TAG_W] == TAG_W'(e)) &&
            busy[e] && !done[e]) begin
          wb_hit[e] = 1'b1;
          wb_res[e] = rob.wb_result_i[k*RES_W +: RES_W];
          wb_flg[e] = rob.wb_flags_i[k*FLAG_W +: FLAG_W];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head     <= '0;
      tail     <= '0;
      busy     <= '0;
      done     <= '0;
      fflags_q <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        rd_q[e]  <= '0;
        res_q[e] <= '0;
        flg_q[e] <= '0;
      end
    end else if (rob.flush_i) begin
      head <= '0;
      tail <= '0;
      busy <= '0;
      done <= '0;
      if (rob.fflags_clr_i) fflags_q <= '0;
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        if (wb_hit[e]) begin
          res_q[e] <= wb_res[e];
          flg_q[e] <= wb_flg[e];
          done[e]  <= 1'b1;
        end
      end
      // Alloc can never hit the retiring entry: that would require a full buffer.
      if (alloc_fire) begin
        busy[tail_idx] <= 1'b1;
        done[tail_idx] <= 1'b0;
        rd_q[tail_idx] <= rob.alloc_rd_i;
        tail           <= tail + PTR_ONE;
      end
      if (ret_fire) begin
        busy[head_idx] <= 1'b0;
        head           <= head + PTR_ONE;
        fflags_q       <= (rob.fflags_clr_i ? '0 : fflags_q) | rob.ret_flags_o;
      end else if (rob.fflags_clr_i) begin
        fflags_q <= '0;
      end
    end
  end
endmodule

// File: tb/tb_fp_result_rob.sv
// Scoreboard bench for fp_result_rob: issue-order expectations queued at alloc, checked at retire.
module tb_fp_result_rob;
  localparam int DEPTH  = 4;
  localparam int NUM_WB = 2;
  localparam int RES_W  = 64;
  localparam int FLAG_W = 5;
  localparam int TAG_W  = $clog2(DEPTH);

  typedef struct {
    logic [4:0]        rd;
    logic [RES_W-1:0]  res;
    logic [FLAG_W-1:0] fl;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fp_result_rob_if #(.DEPTH(DEPTH), .NUM_WB(NUM_WB), .RES_W(RES_W), .FLAG_W(FLAG_W)) bus ();
  fp_result_rob #(.DEPTH(DEPTH), .NUM_WB(NUM_WB), .RES_W(RES_W), .FLAG_W(FLAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rob   (bus)
  );

  int   n_pass = 0;
  int   n_total = 0;
  exp_t sb[$];
  exp_t model[DEPTH];
  exp_t popped;
  int   exp_tail = 0;

  task automatic idle();
    bus.alloc_valid_i = 1'b0;  bus.alloc_rd_i = '0;
    bus.wb_valid_i = '0;       bus.wb_tag_i = '0;
    bus.wb_result_i = '0;      bus.wb_flags_i = '0;
    bus.ret_ready_i = 1'b0;    bus.flush_i = 1'b0;  bus.fflags_clr_i = 1'b0;
  endtask

  // Scoreboard pops on every accepted retire at the falling edge, then advances to post-edge.
  task automatic step();
    @(negedge clk);
    if (rst_n && bus.ret_valid_o && bus.ret_ready_i && !bus.flush_i) begin
      n_total++;
      if (sb.size() == 0) begin
        $display("FAIL retire_unexpected: retired rd=%0d with nothing outstanding", bus.ret_rd_o);
      end else begin
        popped = sb.pop_front();
        if (bus.ret_rd_o !== popped.rd || bus.ret_result_o !== popped.res || bus.ret_flags_o !== popped.fl)
          $display("FAIL retire_data: got rd=%0d res=%h fl=%b want rd=%0d res=%h fl=%b",
                   bus.ret_rd_o, bus.ret_result_o, bus.ret_flags_o, popped.rd, popped.res, popped.fl);
        else n_pass++;
      end
    end
    @(posedge clk);
    #2;
  endtask

  task automatic push_alloc(input logic [4:0] rd, input logic [FLAG_W-1:0] fl);
    exp_t e;
    e.rd  = rd;
    e.res = {$urandom, $urandom};
    e.fl  = fl;
    model[exp_tail % DEPTH] = e;
    sb.push_back(e);
    exp_tail++;
    bus.alloc_valid_i = 1'b1;
    bus.alloc_rd_i    = rd;
  endtask

  task automatic set_wb(input int port, input int tag);
    bus.wb_valid_i[port]                     = 1'b1;
    bus.wb_tag_i[port*TAG_W +: TAG_W]        = TAG_W'(tag);
    bus.wb_result_i[port*RES_W +: RES_W]     = model[tag].res;
    bus.wb_flags_i[port*FLAG_W +: FLAG_W]    = model[tag].fl;
  endtask

  task automatic reset_dut();
    idle();
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    sb.delete();
    exp_tail = 0;
  endtask

  task automatic test_reset();
    idle();
    #1 rst_n = 1'b0;
    #2;
    n_total++; if (bus.alloc_ready_o !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.alloc_ready_o); else n_pass++;
    n_total++; if (bus.alloc_tag_o !== 2'd0) $display("FAIL reset_tag: got %0d want 0", bus.alloc_tag_o); else n_pass++;
    n_total++; if (bus.ret_valid_o !== 1'b0) $display("FAIL reset_ret_valid: got %b want 0", bus.ret_valid_o); else n_pass++;
    n_total++; if (bus.ret_rd_o !== 5'd0) $display("FAIL reset_ret_rd: got %0d want 0", bus.ret_rd_o); else n_pass++;
    n_total++; if (bus.ret_result_o !== 64'd0) $display("FAIL reset_ret_result: got %h want 0", bus.ret_result_o); else n_pass++;
    n_total++; if (bus.ret_flags_o !== 5'd0) $display("FAIL reset_ret_flags: got %b want 0", bus.ret_flags_o); else n_pass++;
    n_total++; if (bus.fflags_o !== 5'd0) $display("FAIL reset_fflags: got %b want 0", bus.fflags_o); else n_pass++;
    n_total++; if (bus.empty_o !== 1'b1) $display("FAIL reset_empty: got %b want 1", bus.empty_o); else n_pass++;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step();
    n_total++; if (bus.empty_o !== 1'b1) $display("FAIL release_empty: got %b want 1", bus.empty_o); else n_pass++;
  endtask

  task automatic test_alloc_full();
    for (int i = 0; i < 4; i++) begin
      n_total++; if (bus.alloc_ready_o !== 1'b1) $display("FAIL full_ready_%0d: got %b want 1", i, bus.alloc_ready_o); else n_pass++;
      n_total++; if (bus.alloc_tag_o !== 2'(i)) $display("FAIL full_tag_%0d: got %0d want %0d", i, bus.alloc_tag_o, i); else n_pass++;
      push_alloc(5'(i + 1), 5'($urandom));
      step();
    end
    bus.alloc_rd_i = 5'd5;
    n_total++; if (bus.alloc_ready_o !== 1'b0) $display("FAIL full_stall: got %b want 0", bus.alloc_ready_o); else n_pass++;
    n_total++; if (bus.empty_o !== 1'b0) $display("FAIL full_empty: got %b want 0", bus.empty_o); else n_pass++;
    step();
    n_total++; if (bus.alloc_ready_o !== 1'b0) $display("FAIL full_held: got %b want 0", bus.alloc_ready_o); else n_pass++;
    set_wb(0, 0);
    step();
    bus.wb_valid_i = '0;
    n_total++; if (bus.ret_valid_o !== 1'b1) $display("FAIL full_head_done: got %b want 1", bus.ret_valid_o); else n_pass++;
    bus.ret_ready_i = 1'b1;
    n_total++; if (bus.alloc_ready_o !== 1'b0) $display("FAIL full_no_bypass: got %b want 0", bus.alloc_ready_o); else n_pass++;
    step();
    bus.ret_ready_i = 1'b0;
    n_total++; if (bus.alloc_ready_o !== 1'b1) $display("FAIL full_freed: got %b want 1", bus.alloc_ready_o); else n_pass++;
    n_total++; if (bus.alloc_tag_o !== 2'd0) $display("FAIL full_reuse_tag: got %0d want 0", bus.alloc_tag_o); else n_pass++;
    push_alloc(5'd5, 5'($urandom));
    step();
    bus.alloc_valid_i = 1'b0;
    n_total++; if (bus.alloc_ready_o !== 1'b0) $display("FAIL full_again: got %b want 0", bus.alloc_ready_o); else n_pass++;
    reset_dut();
  endtask

  task automatic test_ooo_wb();
    for (int i = 0; i < 3; i++) begin
      n_total++; if (bus.alloc_tag_o !== 2'(i)) $display("FAIL ooo_tag_%0d: got %0d want %0d", i, bus.alloc_tag_o, i); else n_pass++;
      push_alloc(5'(i), 5'($urandom));
      step();
    end
    bus.alloc_valid_i = 1'b0;
    bus.ret_ready_i = 1'b1;
    set_wb(1, 2);
    n_total++; if (bus.ret_valid_o !== 1'b0) $display("FAIL ooo_none_done: got %b want 0", bus.ret_valid_o); else n_pass++;
    step();
    bus.wb_valid_i = '0;
    set_wb(0, 0);
    n_total++; if (bus.ret_valid_o !== 1'b0) $display("FAIL ooo_tail_done_only: got %b want 0", bus.ret_valid_o); else n_pass++;
    step();
    bus.wb_valid_i = '0;
    set_wb(0, 1);
    n_total++; if (bus.ret_valid_o !== 1'b1) $display("FAIL ooo_head_valid: got %b want 1", bus.ret_valid_o); else n_pass++;
    n_total++; if (bus.ret_rd_o !== 5'd0) $display("FAIL ooo_order0: got %0d want 0", bus.ret_rd_o); else n_pass++;
    step();
    bus.wb_valid_i = '0;
    n_total++; if (bus.ret_rd_o !== 5'd1 || bus.ret_valid_o !== 1'b1) $display("FAIL ooo_order1: got rd=%0d v=%b want rd=1 v=1", bus.ret_rd_o, bus.ret_valid_o); else n_pass++;
    step();
    n_total++; if (bus.ret_rd_o !== 5'd2 || bus.ret_valid_o !== 1'b1) $display("FAIL ooo_order2: got rd=%0d v=%b want rd=2 v=1", bus.ret_rd_o, bus.ret_valid_o); else n_pass++;
    step();
    n_total++; if (bus.empty_o !== 1'b1 || bus.ret_valid_o !== 1'b0) $display("FAIL ooo_drained: got empty=%b v=%b want 1 0", bus.empty_o, bus.ret_valid_o); else n_pass++;
    reset_dut();
  endtask

  task automatic test_concurrent();
    push_alloc(5'd10, 5'($urandom));
    step();
    push_alloc(5'd11, 5'($urandom));
    set_wb(0, 0);
    step();
    bus.wb_valid_i = '0;
    n_total++; if (bus.ret_valid_o !== 1'b1) $display("FAIL conc_head_done: got %b want 1", bus.ret_valid_o); else n_pass++;
    n_total++; if (bus.alloc_tag_o !== 2'd2) $display("FAIL conc_new_tag: got %0d want 2", bus.alloc_tag_o); else n_pass++;
    push_alloc(5'd12, 5'($urandom));
    set_wb(0, 1);
    bus.wb_valid_i[1] = 1'b1;
    bus.wb_tag_i[2*TAG_W-1:TAG_W] = 2'd1;
    bus.wb_result_i[2*RES_W-1:RES_W] = ~model[1].res;
    bus.wb_flags_i[2*FLAG_W-1:FLAG_W] = ~model[1].fl;
    bus.ret_ready_i = 1'b1;
    step();
    idle();
    n_total++; if (bus.ret_valid_o !== 1'b1 || bus.ret_rd_o !== 5'd11) $display("FAIL conc_next_head: got v=%b rd=%0d want v=1 rd=11", bus.ret_valid_o, bus.ret_rd_o); else n_pass++;
    n_total++; if (bus.ret_result_o !== model[1].res) $display("FAIL conc_port_priority: got %h want %h", bus.ret_result_o, model[1].res); else n_pass++;
    n_total++; if (bus.ret_flags_o !== model[1].fl) $display("FAIL conc_flag_priority: got %b want %b", bus.ret_flags_o, model[1].fl); else n_pass++;
    n_total++; if (bus.alloc_tag_o !== 2'd3) $display("FAIL conc_tail: got %0d want 3", bus.alloc_tag_o); else n_pass++;
    push_alloc(5'd13, 5'($urandom));
    step();
    n_total++; if (bus.alloc_ready_o !== 1'b1) $display("FAIL conc_count3: got %b want 1", bus.alloc_ready_o); else n_pass++;
    push_alloc(5'd14, 5'($urandom));
    step();
    bus.alloc_valid_i = 1'b0;
    n_total++; if (bus.alloc_ready_o !== 1'b0) $display("FAIL conc_count4: got %b want 0", bus.alloc_ready_o); else n_pass++;
    reset_dut();
  endtask

  task automatic test_fflags();
    push_alloc(5'd1, 5'b00001);
    step();
    push_alloc(5'd2, 5'b10000);
    step();
    push_alloc(5'd3, 5'b00100);
    step();
    bus.alloc_valid_i = 1'b0;
    set_wb(0, 0);
    set_wb(1, 1);
    step();
    bus.wb_valid_i = '0;
    set_wb(0, 2);
    step();
    bus.wb_valid_i = '0;
    bus.ret_ready_i = 1'b1;
    n_total++; if (bus.fflags_o !== 5'b00000) $display("FAIL ff_initial: got %b want 00000", bus.fflags_o); else n_pass++;
    step();
    n_total++; if (bus.fflags_o !== 5'b00001) $display("FAIL ff_first: got %b want 00001", bus.fflags_o); else n_pass++;
    step();
    n_total++; if (bus.fflags_o !== 5'b10001) $display("FAIL ff_sticky: got %b want 10001", bus.fflags_o); else n_pass++;
    bus.fflags_clr_i = 1'b1;
    step();
    bus.ret_ready_i = 1'b0;
    bus.fflags_clr_i = 1'b0;
    n_total++; if (bus.fflags_o !== 5'b00100) $display("FAIL ff_clr_with_retire: got %b want 00100", bus.fflags_o); else n_pass++;
    n_total++; if (bus.empty_o !== 1'b1) $display("FAIL ff_empty: got %b want 1", bus.empty_o); else n_pass++;
    bus.fflags_clr_i = 1'b1;
    step();
    bus.fflags_clr_i = 1'b0;
    n_total++; if (bus.fflags_o !== 5'b00000) $display("FAIL ff_clr_only: got %b want 00000", bus.fflags_o); else n_pass++;
    reset_dut();
  endtask

  task automatic test_wrap();
    for (int g = 0; g < 3; g++) begin
      for (int i = 0; i < 4; i++) begin
        n_total++; if (bus.alloc_tag_o !== 2'(i)) $display("FAIL wrap_tag_g%0d_%0d: got %0d want %0d", g, i, bus.alloc_tag_o, i); else n_pass++;
        push_alloc(5'(g * 4 + i + 1), 5'($urandom));
        step();
      end
      bus.alloc_valid_i = 1'b0;
      n_total++; if (bus.alloc_ready_o !== 1'b0 || bus.empty_o !== 1'b0) $display("FAIL wrap_full_g%0d: got ready=%b empty=%b want 0 0", g, bus.alloc_ready_o, bus.empty_o); else n_pass++;
      set_wb(0, 3);
      set_wb(1, 1);
      step();
      bus.wb_valid_i = '0;
      set_wb(0, 2);
      set_wb(1, 0);
      step();
      bus.wb_valid_i = '0;
      bus.ret_ready_i = 1'b1;
      repeat (4) step();
      bus.ret_ready_i = 1'b0;
      n_total++; if (bus.empty_o !== 1'b1 || bus.ret_valid_o !== 1'b0 || bus.alloc_ready_o !== 1'b1)
        $display("FAIL wrap_empty_g%0d: got empty=%b v=%b ready=%b want 1 0 1", g, bus.empty_o, bus.ret_valid_o, bus.alloc_ready_o);
      else n_pass++;
    end
    reset_dut();
  endtask

  task automatic test_flush_reset();
    push_alloc(5'd20, 5'b00010);
    step();
    bus.alloc_valid_i = 1'b0;
    set_wb(0, 0);
    step();
    bus.wb_valid_i = '0;
    bus.ret_ready_i = 1'b1;
    step();
    bus.ret_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_alloc(5'(21 + i), 5'($urandom));
      step();
    end
    bus.alloc_valid_i = 1'b0;
    set_wb(0, 1);
    step();
    bus.wb_valid_i = '0;
    n_total++; if (bus.ret_valid_o !== 1'b1) $display("FAIL flush_pre_valid: got %b want 1", bus.ret_valid_o); else n_pass++;
    bus.flush_i = 1'b1;
    bus.alloc_valid_i = 1'b1;
    bus.alloc_rd_i = 5'd30;
    set_wb(0, 2);
    bus.ret_ready_i = 1'b1;
    step();
    idle();
    sb.delete();
    exp_tail = 0;
    n_total++; if (bus.empty_o !== 1'b1) $display("FAIL flush_empty: got %b want 1", bus.empty_o); else n_pass++;
    n_total++; if (bus.ret_valid_o !== 1'b0) $display("FAIL flush_ret_valid: got %b want 0", bus.ret_valid_o); else n_pass++;
    n_total++; if (bus.alloc_tag_o !== 2'd0) $display("FAIL flush_tag: got %0d want 0", bus.alloc_tag_o); else n_pass++;
    n_total++; if (bus.fflags_o !== 5'b00010) $display("FAIL flush_fflags: got %b want 00010", bus.fflags_o); else n_pass++;
    push_alloc(5'd9, 5'b01000);
    step();
    bus.alloc_valid_i = 1'b0;
    set_wb(0, 0);
    step();
    bus.wb_valid_i = '0;
    n_total++; if (bus.ret_valid_o !== 1'b1 || bus.ret_rd_o !== 5'd9) $display("FAIL flush_restart: got v=%b rd=%0d want v=1 rd=9", bus.ret_valid_o, bus.ret_rd_o); else n_pass++;
    bus.ret_ready_i = 1'b1;
    step();
    bus.ret_ready_i = 1'b0;
    n_total++; if (bus.fflags_o !== 5'b01010) $display("FAIL flush_fflags_after: got %b want 01010", bus.fflags_o); else n_pass++;
    push_alloc(5'd10, 5'($urandom));
    step();
    bus.alloc_valid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    n_total++; if (bus.empty_o !== 1'b1 || bus.ret_valid_o !== 1'b0) $display("FAIL arst_state: got empty=%b v=%b want 1 0", bus.empty_o, bus.ret_valid_o); else n_pass++;
    n_total++; if (bus.fflags_o !== 5'b00000) $display("FAIL arst_fflags: got %b want 00000", bus.fflags_o); else n_pass++;
    n_total++; if (bus.alloc_tag_o !== 2'd0 || bus.alloc_ready_o !== 1'b1) $display("FAIL arst_alloc: got tag=%0d ready=%b want 0 1", bus.alloc_tag_o, bus.alloc_ready_o); else n_pass++;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    sb.delete();
    exp_tail = 0;
  endtask

  initial begin
    test_reset();
    test_alloc_full();
    test_ooo_wb();
    test_concurrent();
    test_fflags();
    test_wrap();
    test_flush_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
